// File: rtl/spi_controller.sv
// Amiga E-clock bus SPI master for SD card hosting: one byte-wide command/data register,
// mode-0 byte transfers at three speeds, and a running CRC16-CCITT over MOSI or MISO.
module spi_controller #(
    parameter logic [3:0] REG_SEL = 4'hB
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       r_w,
    input  logic       _cs,
    input  logic       e,
    input  logic [3:0] rs,
    inout  wire  [7:0] data,
    input  logic       miso,
    output logic       mosi,
    output logic       sclk,
    output logic [3:0] _ss
);

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_WRITE   = 2'd1,
        MODE_READ    = 2'd2,
        MODE_CRCREAD = 2'd3
    } mode_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
    endfunction

    logic        e_meta_r, e_sync_r, e_prev_r, cs_meta_r, cs_sync_r;
    logic        acc_r, acc_rd_r;
    logic [7:0]  wbyte_r;
    mode_t       mode_r;
    logic [1:0]  speed_r;
    logic [3:0]  ss_n_r;
    logic        crc_src_r, crc_hi_r;
    logic [15:0] crc_r;
    logic [7:0]  rx_r, shift_r;
    logic        busy_r, sclk_r, mosi_r;
    logic [2:0]  bit_cnt_r;
    logic [4:0]  div_cnt_r;

    logic        e_rise_s, e_fall_s, commit_s, drive_s;
    logic        start_s, crc_clr_s;
    logic [7:0]  start_byte_s, rdata_s;
    logic [4:0]  half_s;

    assign e_rise_s = e_sync_r & ~e_prev_r;
    assign e_fall_s = ~e_sync_r & e_prev_r;
    assign commit_s = e_fall_s & acc_r;
    assign drive_s  = ~_cs & r_w & (rs == REG_SEL);
    assign data     = drive_s ? rdata_s : 8'hzz;
    assign mosi     = mosi_r;
    assign sclk     = sclk_r;
    assign _ss      = ss_n_r;

    // Read data reflects pre-commit state for the whole access.
    always_comb begin
        case (mode_r)
            MODE_IDLE:    rdata_s = {7'b0000000, busy_r};
            MODE_WRITE:   rdata_s = rx_r;
            MODE_READ:    rdata_s = rx_r;
            MODE_CRCREAD: rdata_s = crc_hi_r ? crc_r[15:8] : crc_r[7:0];
            default:      rdata_s = 8'h00;
        endcase
    end

    // Half-period of sclk minus one, in clk cycles.
    always_comb begin
        case (speed_r)
            2'b00:   half_s = 5'd31;
            2'b01:   half_s = 5'd3;
            default: half_s = 5'd0;
        endcase
    end

    // Decode which committed accesses start a transfer or clear the CRC.
    always_comb begin
        start_s      = 1'b0;
        start_byte_s = 8'hFF;
        crc_clr_s    = 1'b0;
        if (commit_s) begin
            case (mode_r)
                MODE_IDLE:  crc_clr_s = ~acc_rd_r & (wbyte_r[7:5] == 3'b011);
                MODE_WRITE: begin
                    start_s      = ~acc_rd_r;
                    start_byte_s = wbyte_r;
                end
                MODE_READ:  start_s = acc_rd_r;
                default:    start_s = 1'b0;
            endcase
        end else begin
            start_s = 1'b0;
        end
    end

    // Synchronise the asynchronous strobes and capture each access at E rise.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            e_meta_r  <= 1'b0;
            e_sync_r  <= 1'b0;
            e_prev_r  <= 1'b0;
            cs_meta_r <= 1'b1;
            cs_sync_r <= 1'b1;
            acc_r     <= 1'b0;
            acc_rd_r  <= 1'b1;
            wbyte_r   <= 8'h00;
        end else begin
            e_meta_r  <= e;
            e_sync_r  <= e_meta_r;
            e_prev_r  <= e_sync_r;
            cs_meta_r <= _cs;
            cs_sync_r <= cs_meta_r;
            if (e_rise_s) begin
                acc_r    <= ~cs_sync_r & (rs == REG_SEL);
                acc_rd_r <= r_w;
                wbyte_r  <= data;
            end else if (e_fall_s) begin
                acc_r <= 1'b0;
            end
        end
    end

    // Mode, configuration and CRC byte pointer updates at access commit.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            mode_r    <= MODE_IDLE;
            speed_r   <= 2'b00;
            ss_n_r    <= 4'hF;
            crc_src_r <= 1'b0;
            crc_hi_r  <= 1'b1;
        end else if (commit_s) begin
            case (mode_r)
                MODE_IDLE: begin
                    if (!acc_rd_r) begin
                        case (wbyte_r[7:5])
                            3'b001:  speed_r   <= wbyte_r[1:0];
                            3'b010:  ss_n_r    <= ~wbyte_r[3:0];
                            3'b011:  crc_src_r <= wbyte_r[0];
                            3'b100:  mode_r    <= MODE_READ;
                            3'b101:  mode_r    <= MODE_WRITE;
                            3'b110: begin
                                mode_r   <= MODE_CRCREAD;
                                crc_hi_r <= 1'b1;
                            end
                            default: mode_r <= MODE_IDLE;
                        endcase
                    end
                end
                MODE_WRITE:   if (acc_rd_r) mode_r <= MODE_IDLE;
                MODE_READ:    if (!acc_rd_r) mode_r <= MODE_IDLE;
                MODE_CRCREAD: begin
                    if (acc_rd_r) crc_hi_r <= ~crc_hi_r;
                    else          mode_r   <= MODE_IDLE;
                end
                default: mode_r <= MODE_IDLE;
            endcase
        end
    end

    // Mode-0 shift engine: sample MISO and advance CRC on rising sclk, shift MOSI on falling.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            busy_r    <= 1'b0;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b1;
            shift_r   <= 8'hFF;
            bit_cnt_r <= 3'd0;
            div_cnt_r <= 5'd0;
            rx_r      <= 8'h00;
            crc_r     <= 16'h0000;
        end else begin
            if (start_s && !busy_r) begin
                busy_r    <= 1'b1;
                sclk_r    <= 1'b0;
                shift_r   <= start_byte_s;
                mosi_r    <= start_byte_s[7];
                bit_cnt_r <= 3'd0;
                div_cnt_r <= 5'd0;
            end else if (busy_r) begin
                // >= keeps the divider sane if speed changes mid-byte
                if (div_cnt_r >= half_s) begin
                    div_cnt_r <= 5'd0;
                    sclk_r    <= ~sclk_r;
                    if (!sclk_r) begin
                        rx_r  <= {rx_r[6:0], miso};
                        crc_r <= crc16_step(crc_r, crc_src_r ? miso : mosi_r);
                    end else if (bit_cnt_r == 3'd7) begin
                        busy_r <= 1'b0;
                        mosi_r <= 1'b1;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        shift_r   <= {shift_r[6:0], 1'b0};
                        mosi_r    <= shift_r[6];
                    end
                end else begin
                    div_cnt_r <= div_cnt_r + 5'd1;
                end
            end
            if (crc_clr_s) crc_r <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: CPU E-clock bus driver, SPI slave model with byte queues,
// and a byte-level reference model of received data and CRC16-CCITT.
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       _reset = 1'b1;
    logic       r_w = 1'b1;
    logic       _cs = 1'b1;
    logic       e = 1'b0;
    logic [3:0] rs = 4'h0;
    wire  [7:0] data;
    logic       miso;
    logic       mosi, sclk;
    logic [3:0] _ss;
    logic [7:0] tb_dout = 8'h00;
    logic       tb_oe = 1'b0;

    assign data = tb_oe ? tb_dout : 8'hzz;

    spi_controller #(.REG_SEL(4'hB)) dut (
        .clk(clk), ._reset(_reset), .r_w(r_w), ._cs(_cs), .e(e), .rs(rs),
        .data(data), .miso(miso), .mosi(mosi), .sclk(sclk), ._ss(_ss)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI slave: bytes to send on MISO, bytes captured from MOSI
    logic [7:0] miso_mem [0:1023];
    logic [7:0] mosi_mem [0:1023];
    int         miso_wr = 0, miso_rd = 0, mosi_wr = 0, bit_idx = 0;
    logic [7:0] cur_b = 8'hFF, mosi_acc = 8'h00, miso_nb;

    always_comb begin
        if (bit_idx == 0) miso_nb = (miso_rd < miso_wr) ? miso_mem[miso_rd] : 8'hFF;
        else              miso_nb = cur_b;
        miso = miso_nb[7 - bit_idx];
    end

    always @(posedge sclk) begin
        if (bit_idx == 0) begin
            cur_b <= miso_nb;
            if (miso_rd < miso_wr) miso_rd <= miso_rd + 1;
        end
        mosi_acc <= {mosi_acc[6:0], mosi};
        if (bit_idx == 7) begin
            mosi_mem[mosi_wr] <= {mosi_acc[6:0], mosi};
            mosi_wr <= mosi_wr + 1;
            bit_idx <= 0;
        end else begin
            bit_idx <= bit_idx + 1;
        end
    end

    task automatic push_miso(input logic [7:0] b);
        miso_mem[miso_wr] = b;
        miso_wr++;
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // One CPU access in the E window
    task automatic bus(input logic rd, input logic [7:0] wd, output logic [7:0] rdv);
        @(negedge clk);
        rs = 4'hB; _cs = 1'b0; r_w = rd; tb_dout = wd; tb_oe = ~rd; e = 1'b1;
        repeat (20) @(negedge clk);
        rdv = data;
        e = 1'b0; _cs = 1'b1;
        @(negedge clk);
        tb_oe = 1'b0; r_w = 1'b1;
        repeat (9) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] b);
        logic [7:0] d;
        bus(1'b0, b, d);
    endtask

    task automatic rd(output logic [7:0] v);
        bus(1'b1, 8'h00, v);
    endtask

    task automatic poll_idle(input string tag);
        logic [7:0] v;
        int n = 0;
        do begin
            rd(v);
            n++;
        end while (v[0] && n < 200);
        check_val(tag, {24'h0, v}, 32'h0);
    endtask

    logic [7:0] model_rx = 8'h00;

    task automatic turbo_read(input logic [31:0] word, input string tag);
        logic [7:0] v;
        for (int k = 0; k < 4; k++) push_miso(word[31 - 8*k -: 8]);
        wr(8'h80);
        for (int k = 0; k < 4; k++) begin
            rd(v);
            check_val(tag, {24'h0, v}, {24'h0, (k == 0) ? model_rx : word[31 - 8*(k-1) -: 8]});
        end
        wr(8'h00);
        wr(8'hA0);
        rd(v);
        check_val(tag, {24'h0, v}, {24'h0, word[7:0]});
        model_rx = word[7:0];
    endtask

    task automatic slow_read(input logic [7:0] b, input string tag);
        logic [7:0] v;
        push_miso(b);
        wr(8'hA0);
        wr(8'hFF);
        rd(v);
        poll_idle({tag, "_poll"});
        wr(8'hA0);
        rd(v);
        check_val(tag, {24'h0, v}, {24'h0, b});
        model_rx = b;
    endtask

    task automatic write_bytes(input logic [31:0] word, input logic slow, input string tag);
        logic [7:0] v;
        int base = mosi_wr;
        if (slow) begin
            for (int k = 0; k < 4; k++) begin
                wr(8'hA0);
                wr(word[31 - 8*k -: 8]);
                rd(v);
                poll_idle({tag, "_poll"});
            end
        end else begin
            wr(8'hA0);
            for (int k = 0; k < 4; k++) wr(word[31 - 8*k -: 8]);
            rd(v);
            check_val({tag, "_rx"}, {24'h0, v}, 32'h0000_00FF);
        end
        model_rx = 8'hFF;
        check_val({tag, "_count"}, mosi_wr - base, 32'd4);
        check_val(tag, {mosi_mem[base], mosi_mem[base+1], mosi_mem[base+2], mosi_mem[base+3]}, word);
        check_val({tag, "_idle"}, {30'h0, sclk, mosi}, 32'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [7:0]  rb [0:5];
        logic [15:0] crc_m;

        #2 _reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_pins", {23'h0, _ss, sclk, mosi}, {23'h0, 4'hF, 1'b0, 1'b1});
        _reset = 1'b1;
        repeat (3) @(negedge clk);
        rd(v);
        check_val("idle_rd", {24'h0, v}, 32'h0);

        // turbo read
        wr(8'h22);
        wr(8'h41);
        turbo_read(32'hDEADBEEF, "turbo_rd");
        check_val("ss_sel", {28'h0, _ss}, 32'hE);
        for (int i = 0; i < 2; i++) turbo_read($urandom, "turbo_rd_rand");

        // slow reads at 250 kHz and 2 MHz
        wr(8'h20);
        slow_read(8'hAB, "slow_rd");
        slow_read(8'hBA, "slow_rd");
        slow_read(8'h12, "slow_rd");
        slow_read(8'h34, "slow_rd");
        wr(8'h21);
        for (int i = 0; i < 2; i++) slow_read(8'($urandom), "mid_rd_rand");

        // slow writes
        wr(8'h20);
        wr(8'h41);
        write_bytes(32'h12345678, 1'b1, "slow_wr");
        wr(8'h21);
        write_bytes($urandom, 1'b1, "mid_wr_rand");

        // turbo writes and deselect
        wr(8'h22);
        write_bytes(32'h9ABCDEF0, 1'b0, "turbo_wr");
        write_bytes($urandom, 1'b0, "turbo_wr_rand");
        wr(8'h40);
        check_val("ss_desel", {28'h0, _ss}, 32'hF);

        // CRC over MOSI for a 512-byte block of 0xFF
        crc_m = 16'h0000;
        wr(8'h60);
        wr(8'hA0);
        for (int i = 0; i < 512; i++) begin
            wr(8'hFF);
            crc_m = crc_byte(crc_m, 8'hFF);
        end
        rd(v);
        wr(8'hC0);
        rd(v);
        check_val("crc_mosi_hi", {24'h0, v}, {24'h0, crc_m[15:8]});
        rd(v);
        check_val("crc_mosi_lo", {24'h0, v}, {24'h0, crc_m[7:0]});
        rd(v);
        check_val("crc_ptr_wrap", {24'h0, v}, {24'h0, crc_m[15:8]});
        wr(8'h00);

        // CRC over MISO for random read bytes
        crc_m = 16'h0000;
        wr(8'h61);
        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            push_miso(rb[i]);
            crc_m = crc_byte(crc_m, rb[i]);
        end
        wr(8'h80);
        for (int i = 0; i < 6; i++) begin
            rd(v);
            check_val("miso_rd", {24'h0, v}, {24'h0, (i == 0) ? model_rx : rb[i-1]});
        end
        wr(8'h00);
        wr(8'hA0);
        rd(v);
        check_val("miso_rd_last", {24'h0, v}, {24'h0, rb[5]});
        wr(8'hC0);
        rd(v);
        check_val("crc_miso_hi", {24'h0, v}, {24'h0, crc_m[15:8]});
        rd(v);
        check_val("crc_miso_lo", {24'h0, v}, {24'h0, crc_m[7:0]});
        wr(8'h00);

        // async reset during a slow transfer
        wr(8'h20);
        wr(8'h41);
        wr(8'hA0);
        wr(8'h55);
        repeat (100) @(negedge clk);
        check_val("busy_before_rst", {28'h0, _ss}, 32'hE);
        _reset = 1'b0;
        #1;
        check_val("rst_abort", {23'h0, _ss, sclk, mosi}, {23'h0, 4'hF, 1'b0, 1'b1});
        repeat (3) @(negedge clk);
        _reset = 1'b1;
        repeat (3) @(negedge clk);
        rd(v);
        check_val("rst_idle_rd", {24'h0, v}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
